// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit arbiter and uart_tx.
// Optional build macro: UART_ARB_HEADER_EN. When it is defined, the arbiter
// sends one requester-index byte ahead of every message.
package uart_pkg;

  // Byte width used by uart_tx; the arbiter data path must match it.
  localparam int unsigned UART_DATA_WIDTH = 8;

  // Arbiter message states. HDR is only entered when UART_ARB_HEADER_EN is defined.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HDR   = 3'd1,
    FETCH = 3'd2,
    SEND  = 3'd3,
    WAIT  = 3'd4
  } arb_state_t;

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational round-robin picker: returns the first asserted request found
// by scanning upward from rr_ptr with wrap at N_REQ. This also handles an
// N_REQ that is not a power of 2.
module uart_rr_pick #(
  parameter  int unsigned N_REQ = 4,
  localparam int unsigned IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] rr_ptr,
  output logic             found,
  output logic [IDX_W-1:0] idx
);

  // Scan candidates rr_ptr, rr_ptr+1, ... mod N_REQ; the first hit wins.
  always_comb begin
    int unsigned cand;
    cand  = 0;
    found = 1'b0;
    idx   = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      cand = (32'(rr_ptr) + k) % N_REQ;
      if (!found && req[IDX_W'(cand)]) begin
        found = 1'b1;
        idx   = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one uart_tx serializer among N_REQ byte-stream requesters, using
// round-robin arbitration at message granularity. The grant is held from the
// owner's first byte until its last byte has fully left the line (tx_done).
// Optional build macro: UART_ARB_HEADER_EN. When it is defined, each message
// is prefixed on the line with one byte that carries the requester index.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter  int unsigned N_REQ      = 4,
  parameter  int unsigned DATA_WIDTH = UART_DATA_WIDTH,
  localparam int unsigned IDX_W      = $clog2(N_REQ)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [N_REQ-1:0]            req_valid,
  input  logic [N_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [N_REQ-1:0]            req_last,
  output logic [N_REQ-1:0]            req_ready,
  output logic                        tx_valid,
  output logic [DATA_WIDTH-1:0]       tx_data,
  input  logic                        tx_ready,
  input  logic                        tx_done,
  output logic [IDX_W-1:0]            grant,
  output logic                        busy
);

  arb_state_t            state;
  logic [IDX_W-1:0]      rr_ptr;
  logic [DATA_WIDTH-1:0] hold_data;
  logic                  hold_last;

  logic                  pick_found;
  logic [IDX_W-1:0]      pick_idx;
  logic                  own_valid;
  logic [DATA_WIDTH-1:0] own_data;
  logic                  own_last;
  logic [IDX_W-1:0]      next_ptr;

  // One-hot ready vector for a given owner index.
  function automatic logic [N_REQ-1:0] onehot(input logic [IDX_W-1:0] sel);
    return N_REQ'(1) << sel;
  endfunction

  // Round-robin choice among the current requests, starting at rr_ptr.
  uart_rr_pick #(
    .N_REQ (N_REQ)
  ) u_pick (
    .req    (req_valid),
    .rr_ptr (rr_ptr),
    .found  (pick_found),
    .idx    (pick_idx)
  );

  // Select the current owner's valid, byte and last flag.
  always_comb begin
    own_valid = 1'b0;
    own_data  = '0;
    own_last  = 1'b0;
    for (int i = 0; i < int'(N_REQ); i++) begin
      if (grant == IDX_W'(i)) begin
        own_valid = req_valid[i];
        own_data  = req_data[i*DATA_WIDTH +: DATA_WIDTH];
        own_last  = req_last[i];
      end
    end
  end

  // The served requester drops to lowest priority. The wrap is explicit so that
  // an N_REQ that is not a power of 2 works.
  always_comb begin
    next_ptr = grant + IDX_W'(1);
    if (grant == IDX_W'(N_REQ - 1)) next_ptr = '0;
  end

  // The byte on the line is the held byte; it stays stable while tx_valid is high.
  assign tx_data = hold_data;

  // Message FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      grant     <= '0;
      rr_ptr    <= '0;
      busy      <= 1'b0;
      req_ready <= '0;
      tx_valid  <= 1'b0;
      hold_data <= '0;
      hold_last <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_found) begin
            grant <= pick_idx;
            busy  <= 1'b1;
`ifdef UART_ARB_HEADER_EN
            state <= HDR;
`else
            state     <= FETCH;
            req_ready <= onehot(pick_idx);
`endif
          end
        end
`ifdef UART_ARB_HEADER_EN
        HDR: begin
          hold_data <= DATA_WIDTH'(grant);
          hold_last <= 1'b0;
          tx_valid  <= 1'b1;
          state     <= SEND;
        end
`endif
        FETCH: begin
          if (own_valid) begin
            hold_data <= own_data;
            hold_last <= own_last;
            req_ready <= '0;
            tx_valid  <= 1'b1;
            state     <= SEND;
          end
        end
        SEND: begin
          if (tx_ready) begin
            tx_valid <= 1'b0;
            state    <= WAIT;
          end
        end
        WAIT: begin
          if (tx_done) begin
            if (hold_last) begin
              state  <= IDLE;
              busy   <= 1'b0;
              rr_ptr <= next_ptr;
            end else begin
              state     <= FETCH;
              req_ready <= onehot(grant);
            end
          end
        end
        default: begin
          state     <= IDLE;
          busy      <= 1'b0;
          req_ready <= '0;
          tx_valid  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter. It includes per-requester byte
// sources, a uart_tx behavioural model and a scoreboard of the expected
// (grant, byte) sequence on the line.
module tb_uart_tx_arbiter;

  localparam int unsigned N  = 4;
  localparam int unsigned DW = 8;
  localparam int unsigned IW = 2;
  localparam int TX_BIT_CYC  = 4;
`ifdef UART_ARB_HEADER_EN
  localparam bit HDR_EN = 1'b1;
`else
  localparam bit HDR_EN = 1'b0;
`endif

  typedef struct packed {
    logic [IW-1:0] idx;
    logic [DW-1:0] data;
  } exp_t;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [N-1:0]    req_valid = '0;
  logic [N*DW-1:0] req_data = '0;
  logic [N-1:0]    req_last = '0;
  logic [N-1:0]    req_ready;
  logic            tx_valid;
  logic [DW-1:0]   tx_data;
  logic            tx_ready = 1'b1;
  logic            tx_done = 1'b0;
  logic [IW-1:0]   grant;
  logic            busy;

  int tests_run = 0;
  int tests_failed = 0;

  logic [DW:0] src_q [N][$];
  exp_t        exp_q [$];
  logic [N-1:0] fire = '0;
  bit ready_block = 1'b0;
  bit acc_pending = 1'b0;
  bit m_active = 1'b0;
  int m_cnt = 0;
  int accept_cnt = 0;

  always #5 clk = ~clk;

  uart_tx_arbiter #(
    .N_REQ      (N),
    .DATA_WIDTH (DW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_last  (req_last),
    .req_ready (req_ready),
    .tx_valid  (tx_valid),
    .tx_data   (tx_data),
    .tx_ready  (tx_ready),
    .tx_done   (tx_done),
    .grant     (grant),
    .busy      (busy)
  );

  // Requester sources: pop after a handshake and present the head of each queue.
  always @(negedge clk) begin
    for (int i = 0; i < int'(N); i++)
      if (fire[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
    for (int i = 0; i < int'(N); i++) begin
      if (src_q[i].size() > 0) begin
        req_valid[i]          = 1'b1;
        req_data[i*DW +: DW]  = src_q[i][0][DW-1:0];
        req_last[i]           = src_q[i][0][DW];
      end else begin
        req_valid[i]          = 1'b0;
        req_data[i*DW +: DW]  = '0;
        req_last[i]           = 1'b0;
      end
    end
    fire = req_valid & req_ready;
  end

  // uart_tx model: after it accepts a byte, it is busy for a few cycles, pulses done, then goes idle. It also holds the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    tx_done = 1'b0;
    if (acc_pending) begin
      acc_pending = 1'b0;
      m_active    = 1'b1;
      m_cnt       = TX_BIT_CYC;
    end else if (m_active) begin
      if (m_cnt == 0) begin
        m_active = 1'b0;
        tx_done  = 1'b1;
      end else begin
        m_cnt--;
      end
    end
    tx_ready = !m_active && !tx_done && !ready_block;
    if (tx_valid && tx_ready) begin
      acc_pending = 1'b1;
      accept_cnt++;
      tests_run++;
      if (exp_q.size() == 0) begin
        tests_failed++;
        $display("FAIL sb_unexpected: got grant=%0d data=0x%02h, required no byte", grant, tx_data);
      end else begin
        e = exp_q.pop_front();
        if (tx_data !== e.data || grant !== e.idx) begin
          tests_failed++;
          $display("FAIL sb_line_byte: got grant=%0d data=0x%02h, required grant=%0d data=0x%02h",
                   grant, tx_data, e.idx, e.data);
        end
      end
    end
  end

  task automatic send_byte(input int i, input logic [DW-1:0] d, input bit last);
    src_q[i].push_back({last, d});
  endtask

  task automatic expect_byte(input int i, input logic [DW-1:0] d);
    exp_t e;
    e.idx  = IW'(i);
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic expect_start(input int i);
    if (HDR_EN) expect_byte(i, DW'(i));
  endtask

  function automatic bit src_empty();
    bit r;
    r = 1'b1;
    for (int i = 0; i < int'(N); i++) if (src_q[i].size() != 0) r = 1'b0;
    return r;
  endfunction

  task automatic apply_reset();
    @(posedge clk); #1;
    for (int i = 0; i < int'(N); i++) src_q[i].delete();
    exp_q.delete();
    ready_block = 1'b0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    repeat (TX_BIT_CYC + 4) @(posedge clk);
    #1;
  endtask

  task automatic wait_drain(input int budget, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < budget && !ok; c++) begin
      @(posedge clk); #1;
      if (exp_q.size() == 0 && !busy && !m_active && !acc_pending && src_empty()) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    tests_run++; if (req_ready !== '0) begin tests_failed++; $display("FAIL reset_req_ready: got %b, required 0000", req_ready); end
    tests_run++; if (tx_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_tx_valid: got %b, required 0", tx_valid); end
    tests_run++; if (tx_data !== '0) begin tests_failed++; $display("FAIL reset_tx_data: got 0x%02h, required 0x00", tx_data); end
    tests_run++; if (grant !== '0) begin tests_failed++; $display("FAIL reset_grant: got %0d, required 0", grant); end
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b, required 0", busy); end
    tests_run++; if (dut.rr_ptr !== '0) begin tests_failed++; $display("FAIL reset_rr_ptr: got %0d, required 0", dut.rr_ptr); end
    reset = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    tests_run++; if (busy !== 1'b0 || req_ready !== '0) begin tests_failed++; $display("FAIL idle_no_req: got busy=%b req_ready=%b, required 0 and 0000", busy, req_ready); end
  endtask

  task automatic test_single();
    int  dcnt;
    int  n_done;
    bit  prev_busy;
    bit  seen;
    apply_reset();
    expect_start(0);
    expect_byte(0, 8'h41); expect_byte(0, 8'h42); expect_byte(0, 8'h43);
    send_byte(0, 8'h41, 1'b0); send_byte(0, 8'h42, 1'b0); send_byte(0, 8'h43, 1'b1);
    @(negedge clk);
    @(negedge clk);
    tests_run++;
    if (busy !== 1'b1 || grant !== 2'd0 || req_ready !== (HDR_EN ? 4'b0000 : 4'b0001)) begin
      tests_failed++;
      $display("FAIL single_grant_latency: got busy=%b grant=%0d req_ready=%b, required busy=1 grant=0 req_ready=%b",
               busy, grant, req_ready, HDR_EN ? 4'b0000 : 4'b0001);
    end
    @(negedge clk);
    tests_run++;
    if (tx_valid !== 1'b1 || tx_data !== (HDR_EN ? 8'h00 : 8'h41)) begin
      tests_failed++;
      $display("FAIL single_tx_latency: got tx_valid=%b tx_data=0x%02h, required 1 and 0x%02h",
               tx_valid, tx_data, HDR_EN ? 8'h00 : 8'h41);
    end
    n_done = HDR_EN ? 4 : 3;
    dcnt = 0; prev_busy = 1'b1; seen = 1'b0;
    for (int c = 0; c < 400 && !seen; c++) begin
      @(posedge clk); #1;
      if (tx_done) begin
        dcnt++;
        if (dcnt == n_done) begin
          seen = 1'b1;
          tests_run++;
          if (prev_busy !== 1'b1 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL single_busy_drop: got busy before/after=%b/%b, required 1/0", prev_busy, busy);
          end
          tests_run++;
          if (dut.rr_ptr !== 2'd1) begin
            tests_failed++;
            $display("FAIL single_rr_ptr: got %0d, required 1", dut.rr_ptr);
          end
        end
      end
      prev_busy = busy;
    end
    tests_run++;
    if (!seen || exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL single_done_count: got %0d done pulses, %0d bytes pending, required %0d and 0", dcnt, exp_q.size(), n_done);
    end
  endtask

  task automatic test_round_robin();
    bit ok;
    apply_reset();
    send_byte(0, 8'h10, 1'b0); send_byte(0, 8'h11, 1'b1); send_byte(0, 8'h12, 1'b1);
    send_byte(2, 8'h20, 1'b0); send_byte(2, 8'h21, 1'b1);
    send_byte(2, 8'h22, 1'b0); send_byte(2, 8'h23, 1'b1);
    expect_start(0); expect_byte(0, 8'h10); expect_byte(0, 8'h11);
    expect_start(2); expect_byte(2, 8'h20); expect_byte(2, 8'h21);
    expect_start(0); expect_byte(0, 8'h12);
    expect_start(2); expect_byte(2, 8'h22); expect_byte(2, 8'h23);
    wait_drain(1500, ok);
    tests_run++; if (!ok) begin tests_failed++; $display("FAIL rr_drain: got %0d line bytes pending, required 0", exp_q.size()); end
    tests_run++; if (dut.rr_ptr !== 2'd3) begin tests_failed++; $display("FAIL rr_final_ptr: got %0d, required 3", dut.rr_ptr); end
  endtask

  task automatic test_owner_stall();
    bit ok;
    bit found;
    bit bad;
    apply_reset();
    send_byte(1, 8'h31, 1'b0);
    send_byte(3, 8'h71, 1'b1);
    expect_start(1); expect_byte(1, 8'h31); expect_byte(1, 8'h32);
    expect_start(3); expect_byte(3, 8'h71);
    found = 1'b0;
    for (int c = 0; c < 300 && !found; c++) begin
      @(negedge clk);
      if (req_ready === 4'b0010 && src_q[1].size() == 0 && tx_valid === 1'b0) found = 1'b1;
    end
    tests_run++; if (!found) begin tests_failed++; $display("FAIL stall_reach_fetch: got req_ready=%b, required 0010 with source 1 empty", req_ready); end
    bad = 1'b0;
    repeat (50) begin
      @(negedge clk);
      if (grant !== 2'd1 || tx_valid !== 1'b0 || busy !== 1'b1 || req_ready !== 4'b0010) bad = 1'b1;
    end
    tests_run++;
    if (bad) begin
      tests_failed++;
      $display("FAIL stall_hold_grant: got grant=%0d tx_valid=%b busy=%b req_ready=%b, required 1/0/1/0010", grant, tx_valid, busy, req_ready);
    end
    @(posedge clk); #1;
    send_byte(1, 8'h32, 1'b1);
    wait_drain(800, ok);
    tests_run++; if (!ok) begin tests_failed++; $display("FAIL stall_drain: got %0d line bytes pending, required 0", exp_q.size()); end
  endtask

  task automatic test_tx_ready_stall();
    bit ok;
    bit found;
    bit bad;
    int base;
    apply_reset();
    send_byte(2, 8'h5A, 1'b1);
    expect_start(2); expect_byte(2, 8'h5A);
    base = accept_cnt;
    found = 1'b0;
    for (int c = 0; c < 300 && !found; c++) begin
      @(negedge clk);
      if (req_ready[2] === 1'b1) found = 1'b1;
    end
    ready_block = 1'b1;
    found = 1'b0;
    for (int c = 0; c < 10 && !found; c++) begin
      @(negedge clk);
      if (tx_valid === 1'b1) found = 1'b1;
    end
    tests_run++; if (!found) begin tests_failed++; $display("FAIL txstall_valid_rise: got tx_valid=%b, required 1", tx_valid); end
    bad = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (tx_valid !== 1'b1 || tx_data !== 8'h5A) bad = 1'b1;
    end
    tests_run++;
    if (bad) begin
      tests_failed++;
      $display("FAIL txstall_hold: got tx_valid=%b tx_data=0x%02h, required 1 and 0x5a throughout", tx_valid, tx_data);
    end
    tests_run++;
    if (accept_cnt != base + (HDR_EN ? 1 : 0)) begin
      tests_failed++;
      $display("FAIL txstall_no_accept: got %0d accepts, required %0d", accept_cnt - base, HDR_EN ? 1 : 0);
    end
    @(posedge clk); #1;
    ready_block = 1'b0;
    wait_drain(300, ok);
    tests_run++;
    if (!ok || accept_cnt != base + (HDR_EN ? 2 : 1)) begin
      tests_failed++;
      $display("FAIL txstall_single_accept: got %0d accepts drained=%b, required %0d and drained", accept_cnt - base, ok, HDR_EN ? 2 : 1);
    end
  endtask

  task automatic test_reset_mid_message();
    bit found;
    bit bad;
    int base;
    apply_reset();
    send_byte(1, 8'h51, 1'b1);
    send_byte(2, 8'h61, 1'b0); send_byte(2, 8'h62, 1'b1);
    expect_start(1); expect_byte(1, 8'h51);
    expect_start(2); expect_byte(2, 8'h61);
    found = 1'b0;
    for (int c = 0; c < 600 && !found; c++) begin
      @(posedge clk); #1;
      if (exp_q.size() == 0 && busy === 1'b1 && tx_valid === 1'b0 && grant === 2'd2) found = 1'b1;
    end
    tests_run++; if (!found) begin tests_failed++; $display("FAIL rstmid_reach_wait: got grant=%0d busy=%b, required grant 2 in WAIT", grant, busy); end
    for (int i = 0; i < int'(N); i++) src_q[i].delete();
    base = accept_cnt;
    reset = 1'b1;
    @(posedge clk); #1;
    tests_run++;
    if (busy !== 1'b0 || grant !== 2'd0 || dut.rr_ptr !== 2'd0) begin
      tests_failed++;
      $display("FAIL rstmid_state: got busy=%b grant=%0d rr_ptr=%0d, required 0/0/0", busy, grant, dut.rr_ptr);
    end
    tests_run++;
    if (tx_valid !== 1'b0 || tx_data !== '0 || req_ready !== '0) begin
      tests_failed++;
      $display("FAIL rstmid_outputs: got tx_valid=%b tx_data=0x%02h req_ready=%b, required 0/0x00/0000", tx_valid, tx_data, req_ready);
    end
    reset = 1'b0;
    bad = 1'b0;
    repeat (30) begin
      @(posedge clk); #1;
      if (tx_valid !== 1'b0 || busy !== 1'b0 || req_ready !== '0) bad = 1'b1;
    end
    tests_run++;
    if (bad || accept_cnt != base) begin
      tests_failed++;
      $display("FAIL rstmid_abandon: got %0d extra accepts activity=%b, required 0 and quiet", accept_cnt - base, bad);
    end
  endtask

  task automatic test_header_prefix();
    bit ok;
    bit prev_rdy;
    int pulses;
    int base;
    apply_reset();
    base = accept_cnt;
    send_byte(3, 8'hFF, 1'b1);
    expect_start(3); expect_byte(3, 8'hFF);
    pulses = 0; prev_rdy = 1'b0; ok = 1'b0;
    for (int c = 0; c < 300 && !ok; c++) begin
      @(posedge clk); #1;
      if (req_ready[3] === 1'b1 && !prev_rdy) pulses++;
      prev_rdy = req_ready[3];
      if (exp_q.size() == 0 && !busy && !m_active && !acc_pending && src_empty()) ok = 1'b1;
    end
    tests_run++; if (!ok) begin tests_failed++; $display("FAIL hdr_drain: got %0d line bytes pending, required 0", exp_q.size()); end
    tests_run++; if (pulses != 1) begin tests_failed++; $display("FAIL hdr_ready_pulses: got %0d, required 1", pulses); end
    tests_run++;
    if (accept_cnt != base + (HDR_EN ? 2 : 1)) begin
      tests_failed++;
      $display("FAIL hdr_line_count: got %0d bytes, required %0d", accept_cnt - base, HDR_EN ? 2 : 1);
    end
    tests_run++; if (dut.rr_ptr !== 2'd0) begin tests_failed++; $display("FAIL hdr_rr_wrap: got %0d, required 0", dut.rr_ptr); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_owner_stall();
    test_tx_ready_stall();
    test_reset_mid_message();
    test_header_prefix();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got simulation still running, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one uart_tx serializer among N_REQ byte-stream requesters.
- Arbitration is round-robin at message granularity. A grant is held from a requester's first byte until the byte flagged last has fully left the line (uart_tx done).
- Sits between software/packet producers and uart_tx. Drives uart_tx valid/data and consumes its ready/done.

Parameters:
- N_REQ, 4, number of requesters (2..8)
- DATA_WIDTH, 8, byte width; must match uart_tx DATA_WIDTH
- IDX_W, $clog2(N_REQ), grant index width (derived, not overridden)

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- req_valid  input  N_REQ  per-requester byte available
- req_data  input  N_REQ*DATA_WIDTH  requester i byte at [i*DATA_WIDTH +: DATA_WIDTH]
- req_last  input  N_REQ  byte is final byte of message
- req_ready  output  N_REQ  one-hot; byte of granted requester consumed when req_valid&req_ready
- tx_valid  output  1  to uart_tx valid
- tx_data  output  DATA_WIDTH  to uart_tx data
- tx_ready  input  1  from uart_tx ready (high when uart_tx idle)
- tx_done  input  1  from uart_tx done (1-cycle pulse at end of stop bit)
- grant  output  IDX_W  index of current owner; valid while busy
- busy  output  1  message in progress (state != IDLE)

Behaviour:
- Reset values: req_ready=0, tx_valid=0, tx_data=0, grant=0, busy=0, rr_ptr=0, state=IDLE. Reset mid-message abandons the message; no partial-message resume.
- State IDLE: if any req_valid, pick the first asserted index scanning from rr_ptr upward with wrap. Register it in grant and go to FETCH (or HDR with the feature). With no req_valid, stay in IDLE.
- State FETCH: req_ready[grant]=1, all other bits 0.
  - On req_valid[grant]: latch byte into hold_data and req_last into hold_last, then go to SEND.
  - Owner deasserting valid mid-message: stay in FETCH indefinitely with grant held. There is no timeout.
- State SEND: tx_valid=1 and tx_data=hold_data, both registered or state-decoded. On tx_valid&tx_ready go to WAIT. tx_data stays stable while tx_valid is high.
- State WAIT: tx_valid=0. On tx_done:
  - if hold_last, go to IDLE and set rr_ptr=(grant+1) mod N_REQ (explicit wrap for non-power-of-2 N_REQ);
  - otherwise go to FETCH.
- Latency: req_valid in IDLE at cycle 0 gives grant/req_ready at cycle 1. With req_valid held, the byte is latched at cycle 1 and tx_valid rises at cycle 2. Acceptance is at cycle 2 if tx_ready.
- tx_ready low in SEND: hold tx_valid and data.
- tx_done outside WAIT: ignored.
- Simultaneous requests: exactly one grant per IDLE decision. A requester just served has lowest priority next round.
- req_last is sampled only with the consumed byte.
- Back-to-back messages: at least 1 IDLE cycle between messages. The next FETCH cannot precede uart_tx ready.

Optional Feature:
- Macro UART_ARB_HEADER_EN.
- Defined: IDLE goes to HDR, which loads hold_data={zero-pad, grant} and hold_last=0, then goes to SEND. Every message is prefixed on the line with one byte carrying the requester index. req_ready is not asserted in HDR.
- Undefined: HDR state is absent; IDLE goes straight to FETCH, and the line carries payload bytes only.

Decomposition:
- Package uart_pkg: arb_state_t enum {IDLE, HDR, FETCH, SEND, WAIT}, UART_DATA_WIDTH=8 constant shared with uart_tx.
- One sub-module uart_rr_pick: combinational round-robin picker. Inputs are req vector and rr_ptr; outputs are found flag and index. Top holds rr_ptr and the FSM.

Test Plan:
- Single requester 0, 3-byte message 0x41,0x42,0x43 (last on 0x43) -> uart_tx sees exactly 3 accepts in order. busy drops 1 cycle after the third tx_done. rr_ptr becomes 1.
- Requesters 0 and 2 both valid from reset -> grant=0 message completes fully before grant=2. Then requester 0 valid again with 2 still valid -> 2 is served next, and 0 is not re-granted until after 2.
- Requester 1 stalls (req_valid=0 for 50 cycles) between byte 1 and byte 2 -> grant stays 1, tx_valid stays 0, requester 3 is not granted until 1's last byte is done.
- Model uart_tx with tx_ready low for 10 cycles in SEND -> tx_valid and tx_data=0x5A held constant, with a single acceptance.
- Reset asserted in WAIT mid-message -> next cycle all outputs at reset values, rr_ptr=0, pending bytes not sent.
- With UART_ARB_HEADER_EN, requester 3 sends 0xFF (last) -> line byte sequence 0x03 then 0xFF. req_ready[3] pulses once.
